shared_reg_arbiter: RTL

//  Round-robin arbiter that shares one registered holding stage (a DATA_W-wide

---
 rtl/shared_reg_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//
// Round-robin arbiter in front of one shared holding register. Several
// requesters each offer one word through a req/grant handshake. The winning
// word is captured into the shared register and is offered downstream with
// out_valid/out_ready. out_src carries the index of the requester that
// supplied the word.
//
// Ports
//   clock      in   system clock; all state changes on the rising edge
//   reset      in   asynchronous, active-high; clears all state
//   req        in   req[i]=1: requester i holds a valid word
//   req_data   in   word i sits at bits [i*DATA_W +: DATA_W]
//   grant      out  one-hot or zero; grant[i]=1: word i is captured at this edge
//   out_data   out  shared register contents
//   out_src    out  index of the requester that supplied out_data
//   out_valid  out  out_data/out_src hold a word that has not been consumed
//   out_ready  in   the consumer takes the word when out_valid & out_ready
//   stall_err  out  sticky flag: the consumer stalled for STALL_MAX cycles
module shared_reg_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int STALL_MAX = 1000,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    stall_err
);

  localparam int CNT_W = $clog2(STALL_MAX + 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  logic [SRC_W-1:0]   ptr;
  logic [CNT_W-1:0]   stall_cnt;

  logic               capture_en;
  logic               stalled;
  logic               found;
  logic               grant_any;
  logic [SRC_W-1:0]   win;
  logic [SRC_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  sel_data;
  int                 scan_idx;

  // The register can take a new word when it is empty, or when the word it
  // holds leaves at this same edge.
  assign capture_en = (state == EMPTY) || out_ready;
  assign stalled    = (state == FULL) && !out_ready;
  assign out_valid  = (state == FULL);

  // Search the requesters starting at ptr and wrapping around; the first
  // active one wins. The winner's word is muxed out here as well.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    sel_data = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[scan_idx]) begin
        found    = 1'b1;
        win      = SRC_W'(scan_idx);
        sel_data = req_data[scan_idx*DATA_W +: DATA_W];
      end
    end
  end

  // The pointer moves to the requester just after the winner so that the
  // winner has lowest priority on the next grant.
  assign next_ptr = (win == SRC_W'(N_REQ - 1)) ? '0 : win + SRC_W'(1);

  // Grant is held low during reset so that no requester sees a handshake
  // that the register never actually completes.
  assign grant_any = capture_en && found && !reset;

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[win] = 1'b1;
    end
  end

  // Holding register, FSM, round-robin pointer and stall watchdog. A grant
  // takes priority over going empty, which gives back-to-back transfers
  // while the consumer keeps accepting. The stall counter saturates, and the
  // error flag is raised on the edge where the counter reaches the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      ptr       <= '0;
      out_data  <= '0;
      out_src   <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      if (grant_any) begin
        out_data <= sel_data;
        out_src  <= win;
        ptr      <= next_ptr;
        state    <= FULL;
      end else if ((state == FULL) && out_ready) begin
        state <= EMPTY;
      end

      if (stalled) begin
        if (stall_cnt != CNT_W'(STALL_MAX)) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
        if (stall_cnt == CNT_W'(STALL_MAX - 1)) begin
          stall_err <= 1'b1;
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule
